osc_clk_enable_gen: RTL and testbench
=====================================

Name: osc_clk_enable_gen

Overview:
- Parametrised successor to the single-output on-chip oscillator wrapper.
- Takes the fabric RC oscillator clock (25/50 MHz O2F) as CLK and produces NUM_CH independent, runtime-programmable clock-enable ticks and divided square waves.
- Holds all outputs quiet until a startup settle interval expires.
- Downstream fabric logic uses TICK as a clock enable on CLK. CLK_DIV is for status/LED use only and is never used as a clock.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- DIV_W, 16, divider value width.
- SETTLE_CYCLES, 1024, CLK cycles after reset before READY (>=1).
- DEFAULT_DIV, 50, reset divide value for every channel (1 us tick at 50 MHz).

Ports:
- CLK  in  1  fabric oscillator clock (RCOSC_25_50MHZ_O2F).
- RESET  in  1  synchronous, active-high reset.
- DIV_WR_EN  in  1  one-cycle divider write strobe.
- DIV_WR_CH  in  max(1,$clog2(NUM_CH))  target channel index.
- DIV_WR_DATA  in  DIV_W  new divide value.
- CH_EN  in  NUM_CH  per-channel run enable.
- READY  out  1  settle complete.
- DIV_WR_ACK  out  1  one-cycle acknowledge of an accepted write.
- TICK  out  NUM_CH  one-cycle enable pulse per channel period.
- CLK_DIV  out  NUM_CH  50% square wave, period 2*div.

Behaviour:
- **Clock and reset:** single clock domain, CLK. RESET is synchronous, active-high, sampled on CLK rising edge.
- **Reset values:**
  - READY=0, TICK=0, CLK_DIV=0, DIV_WR_ACK=0.
  - FSM in SETTLE, settle counter=0.
  - Shadow div[i]=DEFAULT_DIV, channel counters=0.
- **FSM, SETTLE state:**
  - Settle counter increments each cycle.
  - When counter==SETTLE_CYCLES-1 the FSM moves to RUN, READY registers to 1, and each channel counter loads shadow[i]-1.
  - In SETTLE, TICK and CLK_DIV are held at 0.
- **FSM, RUN state:**
  - RUN persists until RESET.
  - RESET asserted mid-operation returns everything to reset values the next edge, including shadows, and restarts SETTLE.
- **Divide-value rule:** effective div = max(shadow,1). A value of 0 is treated as 1.
- **Channel counting (RUN and CH_EN[i]=1):**
  - Counter decrements each cycle.
  - At counter==0: TICK[i]=1 for that cycle, CLK_DIV[i] toggles (registered, visible next cycle), counter reloads effective div-1.
  - TICK[i] has period exactly div cycles. If READY first reads 1 in cycle R, the first TICK[i] is in cycle R+div-1.
  - div=1 gives TICK continuously high and CLK_DIV toggling every cycle.
- **Channel disabled (CH_EN[i]=0):**
  - TICK[i]=0 combinationally.
  - Counter held at effective div-1.
  - CLK_DIV[i] registers 0.
  - On re-enable in cycle E, the first TICK[i] is in cycle E+div-1.
- **Writes:**
  - Accepted in any FSM state when RESET=0.
  - Valid channel (DIV_WR_CH<NUM_CH): shadow updated at the edge ending the strobe cycle; DIV_WR_ACK=1 for exactly the following cycle.
  - Invalid channel index: write dropped, no ACK.
  - Back-to-back writes: each is acknowledged in sequence. A later write to the same channel wins.
- **Applying new values:**
  - A new shadow takes effect at the channel's next reload (counter==0). The running period is never truncated, so there are no runt CLK_DIV phases.
  - If the write strobe coincides with a reload cycle, that reload uses the old shadow; the new value applies from the following reload.
  - If the channel is disabled or the FSM is in SETTLE, the held/loaded counter value tracks the new shadow the cycle after the write.
- **Registered outputs:** all outputs except TICK are registered. TICK is decoded from the registered counter==0 and CH_EN & READY.

Decomposition:
- Package osc_clk_pkg:
  - FSM enum state_t {SETTLE, RUN}.
  - Localparams DEF_DIV_W=16 and DEF_SETTLE=1024.
  - Function clog2_min1.
- Sub-module osc_div_ch, instantiated NUM_CH times via generate:
  - Contains shadow reg, down-counter, reload logic, TICK decode and CLK_DIV toggle.
  - Inputs: run, en, wr, wr_data.
- The top level holds the settle counter, FSM, write decode and ACK.

Test Plan (SETTLE_CYCLES=16, DEFAULT_DIV=5, NUM_CH=4 unless stated):
- **Settle and default ticks:** release RESET at cycle 0 with CH_EN=4'hF -> READY first high in cycle 16; TICK[all] first high in cycle 20, then every 5 cycles. CLK_DIV period 10.
- **Write timing:** with ch1 running at div=5, write ch1=3 mid-period -> DIV_WR_ACK next cycle. Current 5-cycle period completes, then TICK[1] spacing is 3. Write coinciding with a TICK[1] cycle delays the change by one more period.
- **Edge divide values:** write ch2=0, then ch2=1 -> TICK[2] continuously high after the next reload; CLK_DIV[2] toggles every cycle.
- **Invalid write and enable gating:**
  - NUM_CH=3, write DIV_WR_CH=3 -> no ACK, no channel changes.
  - Drop CH_EN[0] for 7 cycles, then re-enable in cycle E -> TICK[0]=0 and CLK_DIV[0]=0 while disabled; first TICK[0] in E+4.
- **Reset mid-run:** pulse RESET for 1 cycle after several writes -> READY=0 and all TICK/CLK_DIV=0 next cycle; shadows back to 5; READY re-asserts 16 cycles after RESET deasserts.
- **Write during SETTLE:** write ch3=8 during SETTLE -> first TICK[3] in cycle 16+7=23; ACK still issued.

Source files
------------

// File: rtl/osc_clk_enable_gen_pkg.sv
// ----------------------------------------------------------------------------
// osc_clk_pkg
// Shared types and helpers for the oscillator clock-enable generator:
//   state_t     - settle/run FSM encoding
//   DEF_DIV_W   - default divider width
//   DEF_SETTLE  - default number of settle cycles after reset
//   clog2_min1  - ceil(log2(n)) clamped to at least 1 (for index widths)
// ----------------------------------------------------------------------------
package osc_clk_pkg;

   typedef enum logic [0:0] {
      SETTLE = 1'b0,
      RUN    = 1'b1
   } state_t;

   localparam int DEF_DIV_W  = 16;
   localparam int DEF_SETTLE = 1024;

   // Width of an index able to address n items, never narrower than 1 bit.
   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         return 1;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/osc_clk_enable_gen_div_ch.sv
// ----------------------------------------------------------------------------
// osc_div_ch
// One divider channel: shadow divide register, down-counter, tick decode and
// divided square wave.
//   clk      in  oscillator clock
//   rst      in  synchronous active-high reset
//   run      in  settle interval complete (channel may count)
//   en       in  channel run enable
//   wr       in  write strobe for this channel's shadow register
//   wr_data  in  new divide value
//   tick     out one-cycle enable pulse, once per effective divide period
//   clk_div  out registered square wave, toggles on every tick
// ----------------------------------------------------------------------------
module osc_div_ch
   import osc_clk_pkg::*;
#(
   parameter int DIV_W       = DEF_DIV_W,
   parameter int DEFAULT_DIV = 50
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             en,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_data,
   output logic             tick,
   output logic             clk_div
);

   logic [DIV_W-1:0] shadow;
   logic [DIV_W-1:0] shadow_nxt;
   logic [DIV_W-1:0] cnt;
   logic             active;
   logic             at_zero;

   // Reload value is max(d,1)-1, so a programmed 0 behaves exactly like 1.
   function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] d);
      if (d == {DIV_W{1'b0}}) begin
         return {DIV_W{1'b0}};
      end else begin
         return d - DIV_W'(1'b1);
      end
   endfunction

   assign active  = run & en;
   assign at_zero = (cnt == {DIV_W{1'b0}});
   assign tick    = active & at_zero;

   // Shadow value as it will be after this edge (write takes priority).
   always_comb begin
      shadow_nxt = shadow;
      if (wr) begin
         shadow_nxt = wr_data;
      end else begin
         shadow_nxt = shadow;
      end
   end

   // Shadow divide register.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= DIV_W'(DEFAULT_DIV);
      end else begin
         shadow <= shadow_nxt;
      end
   end

   // Down-counter: while idle it tracks the incoming shadow so a fresh write
   // is already loaded; while running, reloads use the shadow as it stood
   // during the reload cycle, so a coincident write waits one full period.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= {DIV_W{1'b0}};
      end else if (!active) begin
         cnt <= reload_val(shadow_nxt);
      end else if (at_zero) begin
         cnt <= reload_val(shadow);
      end else begin
         cnt <= cnt - DIV_W'(1'b1);
      end
   end

   // Square wave: flips on each tick, forced low while the channel is idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_div <= 1'b0;
      end else if (!active) begin
         clk_div <= 1'b0;
      end else if (at_zero) begin
         clk_div <= ~clk_div;
      end else begin
         clk_div <= clk_div;
      end
   end

endmodule

// File: rtl/osc_clk_enable_gen.sv
// ----------------------------------------------------------------------------
// osc_clk_enable_gen
// Generates NUM_CH runtime-programmable clock-enable ticks and divided square
// waves from the fabric oscillator clock, with all outputs quiet until a
// startup settle interval has elapsed.
//   CLK          in  fabric oscillator clock
//   RESET        in  synchronous active-high reset
//   DIV_WR_EN    in  one-cycle divider write strobe
//   DIV_WR_CH    in  target channel index
//   DIV_WR_DATA  in  new divide value
//   CH_EN        in  per-channel run enable
//   READY        out settle complete
//   DIV_WR_ACK   out one-cycle acknowledge of an accepted write
//   TICK         out per-channel one-cycle enable pulse
//   CLK_DIV      out per-channel 50% square wave (status use only)
// ----------------------------------------------------------------------------
module osc_clk_enable_gen
   import osc_clk_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int DIV_W         = DEF_DIV_W,
   parameter int SETTLE_CYCLES = DEF_SETTLE,
   parameter int DEFAULT_DIV   = 50
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          DIV_WR_EN,
   input  logic [clog2_min1(NUM_CH)-1:0] DIV_WR_CH,
   input  logic [DIV_W-1:0]              DIV_WR_DATA,
   input  logic [NUM_CH-1:0]             CH_EN,
   output logic                          READY,
   output logic                          DIV_WR_ACK,
   output logic [NUM_CH-1:0]             TICK,
   output logic [NUM_CH-1:0]             CLK_DIV
);

   localparam int CH_W  = clog2_min1(NUM_CH);
   localparam int SET_W = clog2_min1(SETTLE_CYCLES);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

   state_t            state;
   state_t            state_nxt;
   logic [SET_W-1:0]  settle_cnt;
   logic              settle_done;
   logic              ready_nxt;
   logic [NUM_CH-1:0] wr_sel;

   assign settle_done = (settle_cnt == SETTLE_LAST);

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= SETTLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic; RUN is left only through reset.
   always_comb begin
      state_nxt = state;
      case (state)
         SETTLE: begin
            if (settle_done) begin
               state_nxt = RUN;
            end else begin
               state_nxt = SETTLE;
            end
         end
         RUN:     state_nxt = RUN;
         default: state_nxt = SETTLE;
      endcase
   end

   // FSM output decode, taken from the next state so READY registers with it.
   always_comb begin
      ready_nxt = 1'b0;
      case (state_nxt)
         RUN:     ready_nxt = 1'b1;
         SETTLE:  ready_nxt = 1'b0;
         default: ready_nxt = 1'b0;
      endcase
   end

   // READY register; also acts as the channels' run qualifier.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         READY <= 1'b0;
      end else begin
         READY <= ready_nxt;
      end
   end

   // Settle counter; freezes once the interval has been reached.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         settle_cnt <= {SET_W{1'b0}};
      end else if ((state == SETTLE) && !settle_done) begin
         settle_cnt <= settle_cnt + SET_W'(1'b1);
      end else begin
         settle_cnt <= settle_cnt;
      end
   end

   // One-hot write select; an out-of-range index selects nothing.
   always_comb begin
      wr_sel = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         if (DIV_WR_EN && (DIV_WR_CH == CH_W'(i))) begin
            wr_sel[i] = 1'b1;
         end else begin
            wr_sel[i] = 1'b0;
         end
      end
   end

   // Acknowledge exactly the writes that landed in a channel.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         DIV_WR_ACK <= 1'b0;
      end else begin
         DIV_WR_ACK <= |wr_sel;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      osc_div_ch #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk     (CLK),
         .rst     (RESET),
         .run     (READY),
         .en      (CH_EN[g]),
         .wr      (wr_sel[g]),
         .wr_data (DIV_WR_DATA),
         .tick    (TICK[g]),
         .clk_div (CLK_DIV[g])
      );
   end

endmodule

// File: tb/tb_osc_clk_enable_gen.sv
// ----------------------------------------------------------------------------
// tb_osc_clk_enable_gen
// Directed bench: a 4-channel instance exercises settle, write timing, edge
// divide values, enable gating, mid-run reset and settle-time writes; a
// 3-channel instance covers out-of-range write indices. Cycle 0 is the first
// cycle with RESET low; inputs change 2 time units after each rising edge and
// outputs are sampled 1 unit later.
// ----------------------------------------------------------------------------
module tb_osc_clk_enable_gen;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [1:0]  wr_ch;
   logic [15:0] wr_data;
   logic [3:0]  ch_en;
   logic        ready;
   logic        ack;
   logic [3:0]  tick;
   logic [3:0]  clk_div;

   logic        wr_en_b;
   logic [1:0]  wr_ch_b;
   logic [15:0] wr_data_b;
   logic [2:0]  ch_en_b;
   logic        ready_b;
   logic        ack_b;
   logic [2:0]  tick_b;
   logic [2:0]  clk_div_b;

   int cyc;
   int n_checks;
   int n_errors;

   osc_clk_enable_gen #(
      .NUM_CH(4), .DIV_W(16), .SETTLE_CYCLES(16), .DEFAULT_DIV(5)
   ) dut (
      .CLK(clk), .RESET(reset), .DIV_WR_EN(wr_en), .DIV_WR_CH(wr_ch),
      .DIV_WR_DATA(wr_data), .CH_EN(ch_en), .READY(ready),
      .DIV_WR_ACK(ack), .TICK(tick), .CLK_DIV(clk_div)
   );

   osc_clk_enable_gen #(
      .NUM_CH(3), .DIV_W(16), .SETTLE_CYCLES(16), .DEFAULT_DIV(5)
   ) dut_b (
      .CLK(clk), .RESET(reset), .DIV_WR_EN(wr_en_b), .DIV_WR_CH(wr_ch_b),
      .DIV_WR_DATA(wr_data_b), .CH_EN(ch_en_b), .READY(ready_b),
      .DIV_WR_ACK(ack_b), .TICK(tick_b), .CLK_DIV(clk_div_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Advance into the next cycle and return the default (idle) write inputs.
   task automatic step();
      @(posedge clk);
      #2;
      cyc     = cyc + 1;
      wr_en   = 1'b0;
      wr_en_b = 1'b0;
   endtask

   task automatic write_div(input logic [1:0] ch, input logic [15:0] d);
      wr_en   = 1'b1;
      wr_ch   = ch;
      wr_data = d;
   endtask

   initial begin
      logic       e;
      logic [3:0] ev;
      n_checks  = 0;
      n_errors  = 0;
      cyc       = -3;
      reset     = 1'b1;
      wr_en     = 1'b0;
      wr_ch     = 2'd0;
      wr_data   = 16'd0;
      ch_en     = 4'hF;
      wr_en_b   = 1'b0;
      wr_ch_b   = 2'd0;
      wr_data_b = 16'd0;
      ch_en_b   = 3'b111;

      // Reset held for a few edges, then released at the start of cycle 0.
      step();
      step();
      step();
      reset = 1'b0;
      #1;
      check_value("rst_ready", 32'(ready), 32'd0);
      check_value("rst_tick", 32'(tick), 32'd0);
      check_value("rst_clkdiv", 32'(clk_div), 32'd0);
      check_value("rst_ack", 32'(ack), 32'd0);

      // Settle, then default divide of 5 on every channel.
      for (int c = 1; c <= 30; c++) begin
         step();
         #1;
         check_value("settle_ready", 32'(ready), 32'(c >= 16));
         ev = ((c >= 20) && ((c - 20) % 5 == 0)) ? 4'hF : 4'h0;
         check_value("default_tick", 32'(tick), 32'(ev));
         check_value("default_tick_b", 32'(tick_b), 32'(ev[2:0]));
         ev = ((c >= 21) && (((c - 21) / 5) % 2 == 0)) ? 4'hF : 4'h0;
         check_value("default_clkdiv", 32'(clk_div), 32'(ev));
      end

      // ch1 -> 3 mid-period at 32, ch1 -> 4 coinciding with a tick at 41.
      for (int c = 31; c <= 52; c++) begin
         step();
         if (c == 32) write_div(2'd1, 16'd3);
         if (c == 41) write_div(2'd1, 16'd4);
         #1;
         e = (c == 35) || (c == 38) || (c == 41) || (c == 44) ||
             (c == 48) || (c == 52);
         check_value("wr_tick1", 32'(tick[1]), 32'(e));
         check_value("wr_tick0", 32'(tick[0]), 32'((c - 20) % 5 == 0));
         check_value("wr_ack", 32'(ack), 32'((c == 33) || (c == 42)));
         case (c)
            36, 42, 49: check_value("wr_clkdiv1", 32'(clk_div[1]), 32'd0);
            39, 45:     check_value("wr_clkdiv1", 32'(clk_div[1]), 32'd1);
            default: ;
         endcase
      end

      // ch2 -> 0 then ch2 -> 1: continuous ticks after the next reload.
      for (int c = 53; c <= 62; c++) begin
         step();
         if (c == 53) write_div(2'd2, 16'd0);
         if (c == 57) write_div(2'd2, 16'd1);
         #1;
         check_value("edge_tick2", 32'(tick[2]), 32'(c >= 55));
         e = (c <= 55) ? 1'b1 : (c % 2 == 1);
         check_value("edge_clkdiv2", 32'(clk_div[2]), 32'(e));
         check_value("edge_ack", 32'(ack), 32'((c == 54) || (c == 58)));
         check_value("edge_tick1", 32'(tick[1]), 32'((c == 56) || (c == 60)));
      end

      // ch0 disabled for cycles 63..69, re-enabled at E=70.
      for (int c = 63; c <= 80; c++) begin
         step();
         ch_en = ((c >= 63) && (c <= 69)) ? 4'hE : 4'hF;
         #1;
         check_value("gate_tick0", 32'(tick[0]), 32'((c == 74) || (c == 79)));
         e = (c == 63) || ((c >= 75) && (c <= 79));
         check_value("gate_clkdiv0", 32'(clk_div[0]), 32'(e));
         check_value("gate_tick3", 32'(tick[3]), 32'((c - 20) % 5 == 0));
         check_value("gate_tick2", 32'(tick[2]), 32'd1);
      end

      // 3-channel instance: index 3 is out of range, index 0 is valid.
      for (int c = 81; c <= 92; c++) begin
         step();
         if (c == 81) begin
            wr_en_b = 1'b1; wr_ch_b = 2'd3; wr_data_b = 16'd2;
         end
         if (c == 84) begin
            wr_en_b = 1'b1; wr_ch_b = 2'd0; wr_data_b = 16'd5;
         end
         #1;
         check_value("inv_ack_b", 32'(ack_b), 32'(c == 85));
         ev = ((c - 20) % 5 == 0) ? 4'h7 : 4'h0;
         check_value("inv_tick_b", 32'(tick_b), 32'(ev[2:0]));
      end

      // Writes, mid-run reset at 96, settle restarts at 97, ch3 written at 100.
      for (int c = 93; c <= 128; c++) begin
         step();
         reset = (c == 96);
         if (c == 93) write_div(2'd0, 16'd7);
         if (c == 94) write_div(2'd3, 16'd9);
         if (c == 100) write_div(2'd3, 16'd8);
         #1;
         if ((c == 94) || (c == 95)) begin
            check_value("pre_rst_ack", 32'(ack), 32'd1);
         end
         if (c >= 97) begin
            check_value("rst2_ready", 32'(ready), 32'(c >= 113));
            check_value("rst2_ack", 32'(ack), 32'(c == 101));
            e = (c >= 117) && ((c - 117) % 5 == 0);
            ev = {((c == 120) || (c == 128)), e, e, e};
            check_value("rst2_tick", 32'(tick), 32'(ev));
         end
         case (c)
            97:  check_value("rst2_clkdiv", 32'(clk_div), 32'h0);
            118: check_value("rst2_clkdiv", 32'(clk_div), 32'h7);
            121: check_value("rst2_clkdiv", 32'(clk_div), 32'hF);
            123: check_value("rst2_clkdiv", 32'(clk_div), 32'h8);
            default: ;
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
